// File: rtl/fetch_ctrl.sv
// fetch_ctrl: owns the PC and sequences instruction fetch with one outstanding req/ack at a time.
// Latency: with zero-wait memory and no stall, one instruction every 2 cycles; first if_valid on 2nd edge after reset.
// Backpressure: stall holds the if_* output register in OUT; a taken branch flushes it even while stalled.
//
// Ports:
//   clk, reset                 rising-edge clock, asynchronous active-high reset
//   mem_req/mem_addr           request to instruction memory (addr stable until mem_ack)
//   mem_ack/mem_rdata          memory return, sampled only while a request is outstanding
//   stall                      decode cannot accept if_* this cycle
//   br_taken/br_pc/br_offset   taken-branch redirect; target = br_pc + 4 + sext(offset) * 4
//   if_valid/if_pc/if_instr    fetched word presented to decode
//   fetch_err                  sticky fetch timeout flag
//
// Optional feature: define FETCH_CTRL_TIMEOUT_EN to add the REQ timeout counter and the ERR
// state. Without it fetch_err is tied low and REQ waits indefinitely for mem_ack.

module fetch_ctrl #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int          TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_pc,
  input  logic [15:0] br_offset,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        fetch_err
);

  // A limit below one would fire the timeout before any memory could respond.
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("fetch_ctrl: TIMEOUT_CYCLES must be at least 1");
  end

`ifdef FETCH_CTRL_TIMEOUT_EN
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_OUT, S_ERR} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_OUT} state_t;
`endif

  state_t      r_state,       w_state_nxt;
  logic [31:0] r_mem_addr,    w_mem_addr_nxt;
  logic        r_if_valid,    w_if_valid_nxt;
  logic [31:0] r_if_pc,       w_if_pc_nxt;
  logic [31:0] r_if_instr,    w_if_instr_nxt;
  logic [31:0] r_pc_next,     w_pc_next_nxt;
  logic        r_kill,        w_kill_nxt;
  logic [31:0] r_redirect_pc, w_redirect_pc_nxt;
  logic [31:0] w_target;

  // Offset is in words: sign-extend and scale by 4; the sum wraps modulo 2^32.
  assign w_target = br_pc + 32'd4 + {{14{br_offset[15]}}, br_offset, 2'b00};

`ifdef FETCH_CTRL_TIMEOUT_EN
  localparam int              CW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0]   TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_tmo_cnt, w_tmo_cnt_nxt;
  logic          r_fetch_err, w_fetch_err_nxt;
  logic          w_tmo_hit;

  // This REQ cycle without ack is the TIMEOUT_CYCLES-th one.
  assign w_tmo_hit = (r_state == S_REQ) && !mem_ack && (r_tmo_cnt == TMO_LAST);
`endif

  always_comb begin
    w_state_nxt       = r_state;
    w_mem_addr_nxt    = r_mem_addr;
    w_if_valid_nxt    = r_if_valid;
    w_if_pc_nxt       = r_if_pc;
    w_if_instr_nxt    = r_if_instr;
    w_pc_next_nxt     = r_pc_next;
    w_kill_nxt        = r_kill;
    w_redirect_pc_nxt = r_redirect_pc;

    case (r_state)
      S_IDLE: begin
        w_state_nxt    = S_REQ;
        w_mem_addr_nxt = br_taken ? w_target : r_pc_next;
      end

      S_REQ: begin
        if (mem_ack) begin
          if (r_kill || br_taken) begin
            // Returning word belongs to the stale path: drop it and reissue.
            // A branch this cycle is newer than the stored redirect.
            w_mem_addr_nxt = br_taken ? w_target : r_redirect_pc;
            w_kill_nxt     = 1'b0;
          end else begin
            w_if_valid_nxt = 1'b1;
            w_if_instr_nxt = mem_rdata;
            w_if_pc_nxt    = r_mem_addr;
            w_pc_next_nxt  = r_mem_addr + 32'd4;
            w_state_nxt    = S_OUT;
          end
        end else if (br_taken) begin
          // mem_addr must stay put until ack; remember where to go afterwards.
          w_kill_nxt        = 1'b1;
          w_redirect_pc_nxt = w_target;
        end
      end

      S_OUT: begin
        if (br_taken) begin
          w_if_valid_nxt = 1'b0;
          w_mem_addr_nxt = w_target;
          w_state_nxt    = S_REQ;
        end else if (!stall) begin
          w_if_valid_nxt = 1'b0;
          w_mem_addr_nxt = r_pc_next;
          w_state_nxt    = S_REQ;
        end
      end

      default: begin
        // ERR (when built in) is left only by reset.
        w_state_nxt = r_state;
      end
    endcase

`ifdef FETCH_CTRL_TIMEOUT_EN
    w_fetch_err_nxt = r_fetch_err;
    w_tmo_cnt_nxt   = '0;
    if ((r_state == S_REQ) && !mem_ack) begin
      w_tmo_cnt_nxt = r_tmo_cnt + 1'b1;
    end
    if (w_tmo_hit) begin
      w_state_nxt     = S_ERR;
      w_fetch_err_nxt = 1'b1;
      w_if_valid_nxt  = 1'b0;
      w_kill_nxt      = r_kill;
      w_tmo_cnt_nxt   = '0;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_mem_addr    <= 32'd0;
      r_if_valid    <= 1'b0;
      r_if_pc       <= 32'd0;
      r_if_instr    <= 32'd0;
      r_pc_next     <= RESET_PC;
      r_kill        <= 1'b0;
      r_redirect_pc <= 32'd0;
    end else begin
      r_state       <= w_state_nxt;
      r_mem_addr    <= w_mem_addr_nxt;
      r_if_valid    <= w_if_valid_nxt;
      r_if_pc       <= w_if_pc_nxt;
      r_if_instr    <= w_if_instr_nxt;
      r_pc_next     <= w_pc_next_nxt;
      r_kill        <= w_kill_nxt;
      r_redirect_pc <= w_redirect_pc_nxt;
    end
  end

`ifdef FETCH_CTRL_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tmo_cnt   <= '0;
      r_fetch_err <= 1'b0;
    end else begin
      r_tmo_cnt   <= w_tmo_cnt_nxt;
      r_fetch_err <= w_fetch_err_nxt;
    end
  end

  assign fetch_err = r_fetch_err;
`else
  assign fetch_err = 1'b0;
`endif

  assign mem_req  = (r_state == S_REQ);
  assign mem_addr = r_mem_addr;
  assign if_valid = r_if_valid;
  assign if_pc    = r_if_pc;
  assign if_instr = r_if_instr;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed bench for fetch_ctrl with hand-computed expectations.
// Memory words are 32'hA500_0000 | address so every fetched word identifies its address.
// Inputs change 1 time unit after the rising edge; outputs are checked at that point.

module tb_fetch_ctrl;

  logic        clk;
  logic        reset;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        stall;
  logic        br_taken;
  logic [31:0] br_pc;
  logic [15:0] br_offset;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        fetch_err;

  int n_cmp  = 0;
  int n_fail = 0;

  fetch_ctrl #(
    .RESET_PC       (32'h0000_0000),
    .TIMEOUT_CYCLES (15)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .stall     (stall),
    .br_taken  (br_taken),
    .br_pc     (br_pc),
    .br_offset (br_offset),
    .if_valid  (if_valid),
    .if_pc     (if_pc),
    .if_instr  (if_instr),
    .fetch_err (fetch_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic ack, input logic [31:0] rdata, input logic br,
                     input logic [31:0] bpc, input logic [15:0] boff, input logic st);
    mem_ack   = ack;
    mem_rdata = rdata;
    br_taken  = br;
    br_pc     = bpc;
    br_offset = boff;
    stall     = st;
    @(posedge clk);
    #1;
    mem_ack  = 1'b0;
    br_taken = 1'b0;
  endtask

  // Zero-wait memory: ack in the same cycle as the request.
  task automatic zw(input logic st);
    logic [31:0] w;
    w = mem_req ? (32'hA500_0000 | mem_addr) : 32'd0;
    cyc(mem_req, w, 1'b0, 32'd0, 16'd0, st);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    mem_ack   = 1'b0;
    mem_rdata = 32'd0;
    stall     = 1'b0;
    br_taken  = 1'b0;
    br_pc     = 32'd0;
    br_offset = 16'd0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    chk("rst_mem_req",   {31'd0, mem_req},   32'd0);
    chk("rst_mem_addr",  mem_addr,           32'd0);
    chk("rst_if_valid",  {31'd0, if_valid},  32'd0);
    chk("rst_if_pc",     if_pc,              32'd0);
    chk("rst_if_instr",  if_instr,           32'd0);
    chk("rst_fetch_err", {31'd0, fetch_err}, 32'd0);
    reset = 1'b0;

    // Zero-wait streaming: 0,4,8,C
    zw(1'b0);
    chk("zw_e1_req",   {31'd0, mem_req},  32'd1);
    chk("zw_e1_addr",  mem_addr,          32'h0);
    chk("zw_e1_valid", {31'd0, if_valid}, 32'd0);
    zw(1'b0);
    chk("zw_e2_valid", {31'd0, if_valid}, 32'd1);
    chk("zw_e2_pc",    if_pc,             32'h0);
    chk("zw_e2_instr", if_instr,          32'hA500_0000);
    chk("zw_e2_req",   {31'd0, mem_req},  32'd0);
    zw(1'b0);
    chk("zw_e3_addr",  mem_addr,          32'h4);
    chk("zw_e3_valid", {31'd0, if_valid}, 32'd0);
    zw(1'b0);
    chk("zw_e4_pc",    if_pc,             32'h4);
    chk("zw_e4_instr", if_instr,          32'hA500_0004);
    zw(1'b0);
    chk("zw_e5_addr",  mem_addr,          32'h8);
    zw(1'b0);
    chk("zw_e6_valid", {31'd0, if_valid}, 32'd1);
    chk("zw_e6_pc",    if_pc,             32'h8);
    chk("zw_e6_instr", if_instr,          32'hA500_0008);
    zw(1'b0);
    chk("zw_e7_addr",  mem_addr,          32'hC);
    chk("zw_e7_req",   {31'd0, mem_req},  32'd1);

    // Ack delayed 3 cycles on address 0x8
    do_reset();
    repeat (5) zw(1'b0);
    chk("dly_c1_req",  {31'd0, mem_req}, 32'd1);
    chk("dly_c1_addr", mem_addr,         32'h8);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 32'hDEAD_0000, 1'b0, 32'd0, 16'd0, 1'b0);
      chk("dly_wait_req",  {31'd0, mem_req}, 32'd1);
      chk("dly_wait_addr", mem_addr,         32'h8);
    end
    cyc(1'b1, 32'hA500_0008, 1'b0, 32'd0, 16'd0, 1'b0);
    chk("dly_valid", {31'd0, if_valid}, 32'd1);
    chk("dly_pc",    if_pc,             32'h8);
    chk("dly_instr", if_instr,          32'hA500_0008);

    repeat (5) zw(1'b0);
    chk("pre_br_addr", mem_addr, 32'h14);

    // Redirect while 0x14 is outstanding: target = 0x10 + 4 - 8 = 0xC
    cyc(1'b0, 32'd0, 1'b1, 32'h10, 16'hFFFE, 1'b0);
    chk("kill_addr_hold", mem_addr,         32'h14);
    chk("kill_req",       {31'd0, mem_req}, 32'd1);
    cyc(1'b0, 32'd0, 1'b0, 32'd0, 16'd0, 1'b0);
    cyc(1'b1, 32'hA500_0014, 1'b0, 32'd0, 16'd0, 1'b0);
    chk("kill_drop_valid", {31'd0, if_valid}, 32'd0);
    chk("kill_new_addr",   mem_addr,          32'hC);
    chk("kill_new_req",    {31'd0, mem_req},  32'd1);
    zw(1'b0);
    chk("kill_out_valid", {31'd0, if_valid}, 32'd1);
    chk("kill_out_pc",    if_pc,             32'hC);
    chk("kill_out_instr", if_instr,          32'hA500_000C);

    // Stall held 5 cycles; one stray ack in OUT must be ignored
    for (int i = 0; i < 5; i++) begin
      cyc((i == 2), 32'hDEAD_BEEF, 1'b0, 32'd0, 16'd0, 1'b1);
      chk("stall_valid", {31'd0, if_valid}, 32'd1);
      chk("stall_pc",    if_pc,             32'hC);
      chk("stall_instr", if_instr,          32'hA500_000C);
      chk("stall_req",   {31'd0, mem_req},  32'd0);
    end
    zw(1'b0);
    chk("unstall_addr",  mem_addr,          32'h10);
    chk("unstall_req",   {31'd0, mem_req},  32'd1);
    chk("unstall_valid", {31'd0, if_valid}, 32'd0);
    zw(1'b0);
    chk("unstall_pc",    if_pc,             32'h10);
    cyc(1'b0, 32'd0, 1'b0, 32'd0, 16'd0, 1'b1);
    // Branch during stall, wrapping: 0xFFFFFFF8 + 4 + 8 = 0x4 mod 2^32
    cyc(1'b0, 32'd0, 1'b1, 32'hFFFF_FFF8, 16'h0002, 1'b1);
    chk("stall_br_valid", {31'd0, if_valid}, 32'd0);
    chk("stall_br_addr",  mem_addr,          32'h4);
    chk("stall_br_req",   {31'd0, mem_req},  32'd1);
    zw(1'b0);
    chk("wrap_pc",    if_pc,    32'h4);
    chk("wrap_instr", if_instr, 32'hA500_0004);
    // Branch in OUT without stall, positive offset: 0x100 + 4 + 12 = 0x110
    cyc(1'b0, 32'd0, 1'b1, 32'h100, 16'h0003, 1'b0);
    chk("out_br_addr",  mem_addr,          32'h110);
    chk("out_br_valid", {31'd0, if_valid}, 32'd0);

    // Reset mid-REQ with ack during reset
    reset   = 1'b1;
    mem_ack = 1'b1;
    mem_rdata = 32'h1234_5678;
    #1;
    chk("mid_rst_req",  {31'd0, mem_req}, 32'd0);
    chk("mid_rst_addr", mem_addr,         32'd0);
    @(posedge clk);
    #1;
    chk("mid_rst_valid", {31'd0, if_valid}, 32'd0);
    chk("mid_rst_pc",    if_pc,             32'd0);
    chk("mid_rst_instr", if_instr,          32'd0);
    reset   = 1'b0;
    mem_ack = 1'b0;
    zw(1'b0);
    chk("post_rst_addr", mem_addr,         32'h0);
    chk("post_rst_req",  {31'd0, mem_req}, 32'd1);

    // Branch in IDLE: 0x20 + 4 + 4 = 0x28
    do_reset();
    cyc(1'b0, 32'd0, 1'b1, 32'h20, 16'h0001, 1'b0);
    chk("idle_br_addr", mem_addr,         32'h28);
    chk("idle_br_req",  {31'd0, mem_req}, 32'd1);

`ifdef FETCH_CTRL_TIMEOUT_EN
    do_reset();
    cyc(1'b0, 32'd0, 1'b0, 32'd0, 16'd0, 1'b0);
    for (int i = 0; i < 14; i++) begin
      cyc(1'b0, 32'd0, 1'b0, 32'd0, 16'd0, 1'b0);
      chk("tmo_wait_err", {31'd0, fetch_err}, 32'd0);
    end
    cyc(1'b0, 32'd0, 1'b0, 32'd0, 16'd0, 1'b0);
    chk("tmo_err", {31'd0, fetch_err}, 32'd1);
    chk("tmo_req", {31'd0, mem_req},   32'd0);
    cyc(1'b1, 32'd0, 1'b1, 32'h40, 16'h0001, 1'b0);
    chk("err_br_req",   {31'd0, mem_req},   32'd0);
    chk("err_br_err",   {31'd0, fetch_err}, 32'd1);
    chk("err_br_valid", {31'd0, if_valid},  32'd0);
    do_reset();
    chk("err_rst_clear", {31'd0, fetch_err}, 32'd0);
`else
    chk("no_tmo_err", {31'd0, fetch_err}, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Sequences the instruction-fetch path and owns the PC.
- Issues one request at a time to a variable-latency instruction memory using a req/ack handshake.
- Presents each fetched word to decode through a valid/stall output register.
- Applies taken-branch redirects, including redirects that arrive while a fetch is already outstanding, by discarding the stale returning word.

Parameters:
- RESET_PC, 32'h0000_0000: first fetch address after reset.
- TIMEOUT_CYCLES, 15: REQ-state cycles without mem_ack before an error is flagged. Used only with FETCH_CTRL_TIMEOUT_EN.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- mem_req  out  1  fetch request to instruction memory.
- mem_addr  out  32  byte address of the request.
- mem_ack  in  1  memory returns mem_rdata this cycle.
- mem_rdata  in  32  instruction word, valid when mem_ack=1.
- stall  in  1  decode cannot accept if_* this cycle.
- br_taken  in  1  branch resolved taken, single-cycle pulse.
- br_pc  in  32  PC of the taken branch.
- br_offset  in  16  branch offset field, in words.
- if_valid  out  1  if_instr/if_pc hold a valid instruction.
- if_pc  out  32  PC of if_instr.
- if_instr  out  32  fetched instruction.
- fetch_err  out  1  sticky fetch timeout flag.

Behaviour:
- Clock and reset: reset is asynchronous, active-high; clock is clk. All state updates on the rising edge of clk.
- Reset values:
  - state=IDLE, mem_req=0, mem_addr=0, if_valid=0, if_pc=0, if_instr=0, fetch_err=0.
  - pc_next=RESET_PC, kill=0, redirect_pc=0, timeout counter=0.
- Branch target: target = br_pc + 4 + (sign_extend(br_offset) << 2), computed modulo 2^32. Wrap-around is allowed.
- mem_req is 1 exactly while state=REQ.
- Handshake rule: mem_addr stays stable from request assertion until the cycle mem_ack=1.
- mem_ack outside REQ is ignored.
- States:
  - IDLE: next edge goes to REQ with mem_addr<=pc_next. If br_taken=1 in IDLE, mem_addr<=target instead.
  - REQ, mem_ack=0, br_taken=1: kill<=1, redirect_pc<=target, stay in REQ with mem_addr unchanged. A second br_taken while kill=1 overwrites redirect_pc; the latest redirect wins.
  - REQ, mem_ack=1, and (kill=1 or br_taken=1): drop mem_rdata. mem_addr<=(br_taken ? target : redirect_pc), kill<=0, stay in REQ. br_taken has priority over the stored redirect_pc.
  - REQ, mem_ack=1, otherwise: if_valid<=1, if_instr<=mem_rdata, if_pc<=mem_addr, pc_next<=mem_addr+4, go to OUT.
  - OUT, br_taken=1: if_valid<=0, mem_addr<=target, go to REQ. The redirect flushes the held word even if stall=1.
  - OUT, stall=0: word consumed this cycle. if_valid<=0, mem_addr<=pc_next, go to REQ.
  - OUT, stall=1: hold all outputs.
- Latency with zero-wait memory (ack in the same cycle as req) and no stall: one instruction every 2 cycles.
- The first if_valid occurs on the 2nd rising edge after reset deasserts.
- stall has no effect outside OUT.
- Reset asserted mid-fetch aborts immediately. Any later mem_ack is ignored until the state returns to REQ.

Optional Feature:
- FETCH_CTRL_TIMEOUT_EN defined:
  - The counter increments each REQ cycle with mem_ack=0 and clears on ack or on leaving REQ.
  - When the count reaches TIMEOUT_CYCLES, fetch_err<=1 and the state goes to ERR.
  - ERR: mem_req=0, if_valid=0, br_taken ignored. Only reset exits ERR.
- FETCH_CTRL_TIMEOUT_EN undefined: no counter and no ERR state, fetch_err tied to 0, and REQ waits indefinitely.

Test Plan:
- Reset release, zero-wait memory returning addr-derived words, stall=0 -> mem_addr sequence 0,4,8,C. if_valid pulses every 2nd cycle with if_pc=0,4,8 and the matching if_instr.
- Ack delayed 3 cycles on addr 0x8 -> mem_req held 4 cycles with mem_addr=0x8 stable, then if_pc=0x8 with the returned word.
- br_taken with br_pc=0x10 and br_offset=16'hFFFE, pulsed while the request for 0x14 is pending (ack 2 cycles later) -> word for 0x14 is dropped (if_valid stays 0), next mem_addr=0x0C, then if_pc=0x0C.
- In OUT with stall=1 held 5 cycles -> if_valid, if_pc and if_instr constant and mem_req=0. stall drops -> next request at if_pc+4. br_taken during stall -> if_valid clears and mem_addr=target.
- Reset asserted mid-REQ, with ack arriving during reset -> all outputs at reset values. After release the first fetch is at RESET_PC.
- FETCH_CTRL_TIMEOUT_EN defined, TIMEOUT_CYCLES=15, mem_ack never asserted -> fetch_err=1 after 15 REQ cycles, mem_req=0, br_taken ignored; reset clears fetch_err.
